// File: rtl/ori_pkg.sv
// Shared orientation-histogram constants and FSM state type, also used by the
// descriptor rotation stage.
package ori_pkg;

    localparam int NBINS = 32;
    localparam int BIN_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } ori_state_t;

endpackage

// File: rtl/ori_sat_add.sv
// Combinational saturating adder: unsigned accumulator plus a zero-extended
// magnitude, clamped at the all-ones accumulator value.
module ori_sat_add #(
    parameter int ACC_W = 16,
    parameter int MAG_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [MAG_W-1:0] mag,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W:0] wide;

    // One extra bit catches the carry out, which is the only overflow case.
    assign wide = {1'b0, acc} + (ACC_W + 1)'(mag);
    assign sum  = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/ori_hist_peak.sv
// Magnitude-weighted 32-bin orientation histogram over one keypoint window,
// followed by a sequential scan that reports the dominant bin and its weight.
module ori_hist_peak
    import ori_pkg::*;
#(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    output logic             busy,
    output logic             out_valid,
    output logic [BIN_W-1:0] out_bin,
    output logic [ACC_W-1:0] out_peak
);

    ori_state_t       state;
    ori_state_t       next_state;
    logic [ACC_W-1:0] hist [NBINS];
    logic [BIN_W-1:0] idx;
    logic [BIN_W-1:0] best_bin;
    logic [ACC_W-1:0] best_val;
    logic [BIN_W-1:0] rd_idx;
    logic [ACC_W-1:0] rd_val;
    logic [ACC_W-1:0] add_val;
    logic             accept;
    logic             better;
    logic             scan_end;

    assign accept   = in_valid && in_ready;
    assign scan_end = (idx == BIN_W'(NBINS - 1));

    // One read port serves both the accumulate and the scan path.
    assign rd_idx = (state == SEARCH) ? idx : in_bin;
    assign rd_val = hist[rd_idx];
    assign better = (rd_val > best_val);

    ori_sat_add #(
        .ACC_W(ACC_W),
        .MAG_W(MAG_W)
    ) u_sat_add (
        .acc(rd_val),
        .mag(in_mag),
        .sum(add_val)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (accept && in_last) next_state = SEARCH;
            SEARCH:  if (scan_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == ACCUM);
            busy      <= (next_state != IDLE);
            out_valid <= (next_state == DONE);
        end
    end

    // Bins are cleared only by an accepted start, so results persist in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBINS; i++) hist[i] <= '0;
        end else if (state == IDLE && start) begin
            for (int i = 0; i < NBINS; i++) hist[i] <= '0;
        end else if (state == ACCUM && accept) begin
            hist[in_bin] <= add_val;
        end
    end

    // Strict comparison keeps the earliest (lowest) bin on ties; the final
    // step loads the outputs with the comparison already folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            best_bin <= '0;
            best_val <= '0;
            out_bin  <= '0;
            out_peak <= '0;
        end else if (state == ACCUM && accept && in_last) begin
            idx      <= '0;
            best_bin <= '0;
            best_val <= '0;
        end else if (state == SEARCH) begin
            idx <= idx + 1'b1;
            if (better) begin
                best_bin <= idx;
                best_val <= rd_val;
            end
            if (scan_end) begin
                out_bin  <= better ? idx : best_bin;
                out_peak <= better ? rd_val : best_val;
            end
        end
    end

endmodule

// File: tb/tb_ori_hist_peak.sv
// Randomized self-checking bench for ori_hist_peak: a 16-bit and a 9-bit
// accumulator instance share stimulus and are compared to an array model.
module tb_ori_hist_peak;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [4:0]  in_bin;
    logic [7:0]  in_mag;
    logic        in_last;

    logic        in_ready, busy, out_valid;
    logic [4:0]  out_bin;
    logic [15:0] out_peak;
    logic        s_in_ready, s_busy, s_out_valid;
    logic [4:0]  s_out_bin;
    logic [8:0]  s_out_peak;

    int vectors    = 0;
    int miscompares = 0;

    int mh16 [32];
    int mh9  [32];
    int q_bin[$];
    int q_mag[$];

    int          lat;
    bit          timeout;
    logic [4:0]  got_bin, got_bin_s, hold_bin;
    logic [15:0] got_peak;
    logic [8:0]  got_peak_s;
    logic        ov_after, busy_after;

    ori_hist_peak #(.MAG_W(8), .ACC_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_bin(in_bin), .in_mag(in_mag), .in_last(in_last),
        .busy(busy), .out_valid(out_valid), .out_bin(out_bin), .out_peak(out_peak)
    );

    ori_hist_peak #(.MAG_W(8), .ACC_W(9)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_bin(in_bin), .in_mag(in_mag), .in_last(in_last),
        .busy(s_busy), .out_valid(s_out_valid), .out_bin(s_out_bin), .out_peak(s_out_peak)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mh16[i] = 0;
            mh9[i]  = 0;
        end
    endtask

    task automatic model_acc(input int b, input int m);
        mh16[b] = (mh16[b] + m > 65535) ? 65535 : mh16[b] + m;
        mh9[b]  = (mh9[b] + m > 511) ? 511 : mh9[b] + m;
    endtask

    // Dominant bin = first index holding the maximum weight (0/0 if all empty).
    task automatic model_peak(input bit nine, output int pb, output int pp);
        int v;
        pb = 0;
        pp = 0;
        for (int i = 0; i < 32; i++) begin
            v = nine ? mh9[i] : mh16[i];
            if (v > pp) begin
                pp = v;
                pb = i;
            end
        end
    endtask

    task automatic drive_idle();
        start    = 1'b0;
        in_valid = 1'b0;
        in_bin   = '0;
        in_mag   = '0;
        in_last  = 1'b0;
    endtask

    // Runs one window from the sample queues; noisy mode keeps start high and
    // adds bubbles in ACCUM, and holds in_valid high through SEARCH and DONE.
    task automatic run_window(input bit noisy);
        @(negedge clk);
        start = 1'b1;
        model_clear();
        @(posedge clk);
        for (int k = 0; k < q_bin.size(); k++) begin
            @(negedge clk);
            start = noisy;
            if (noisy && ($urandom % 2 == 0)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_bin   = 5'(q_bin[k]);
            in_mag   = 8'(q_mag[k]);
            in_last  = (k == q_bin.size() - 1);
            model_acc(q_bin[k], q_mag[k]);
            @(posedge clk);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (noisy) begin
                start    = 1'b1;
                in_valid = 1'b1;
                in_bin   = 5'($urandom_range(0, 31));
                in_mag   = 8'($urandom_range(0, 255));
                in_last  = 1'($urandom % 2);
            end else begin
                drive_idle();
            end
        end while (!out_valid && lat < 100);
        timeout    = !out_valid;
        got_bin    = out_bin;
        got_peak   = out_peak;
        got_bin_s  = s_out_bin;
        got_peak_s = s_out_peak;
        @(posedge clk);
        @(negedge clk);
        ov_after   = out_valid | s_out_valid;
        busy_after = busy | s_busy;
        hold_bin   = out_bin;
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, busy, out_valid, out_bin, out_peak} !== 24'd0) begin
            miscompares++;
            $display("[TB] FAIL reset16: got rdy=%b busy=%b ov=%b bin=%0d peak=%0d, need all 0",
                     in_ready, busy, out_valid, out_bin, out_peak);
        end
        vectors++;
        if ({s_in_ready, s_busy, s_out_valid, s_out_bin, s_out_peak} !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL reset9: got rdy=%b busy=%b ov=%b bin=%0d peak=%0d, need all 0",
                     s_in_ready, s_busy, s_out_valid, s_out_bin, s_out_peak);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_handshake: got rdy=%b busy=%b, need 1 1", in_ready, busy);
        end
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(negedge clk);
        drive_idle();
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL last_handshake: got rdy=%b busy=%b, need 0 1", in_ready, busy);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_directed(input string name);
        int eb, ep, eb9, ep9;
        run_window(1'b0);
        model_peak(1'b0, eb, ep);
        model_peak(1'b1, eb9, ep9);
        vectors++;
        if (timeout || lat != 33) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d (timeout=%0d), need 33", name, lat, timeout);
        end
        vectors++;
        if (got_bin !== 5'(eb) || got_peak !== 16'(ep)) begin
            miscompares++;
            $display("[TB] FAIL %s result16: got bin=%0d peak=%0d, need bin=%0d peak=%0d",
                     name, got_bin, got_peak, eb, ep);
        end
        vectors++;
        if (got_bin_s !== 5'(eb9) || got_peak_s !== 9'(ep9)) begin
            miscompares++;
            $display("[TB] FAIL %s result9: got bin=%0d peak=%0d, need bin=%0d peak=%0d",
                     name, got_bin_s, got_peak_s, eb9, ep9);
        end
        vectors++;
        if (ov_after !== 1'b0 || busy_after !== 1'b0 || hold_bin !== 5'(eb)) begin
            miscompares++;
            $display("[TB] FAIL %s done_pulse: got ov=%b busy=%b bin=%0d, need 0 0 %0d",
                     name, ov_after, busy_after, hold_bin, eb);
        end
    endtask

    task automatic load(input int b, input int m, input int n);
        for (int i = 0; i < n; i++) begin
            q_bin.push_back(b);
            q_mag.push_back(m);
        end
    endtask

    task automatic test_basic();
        q_bin.delete(); q_mag.delete();
        load(5, 10, 3); load(7, 20, 1);
        test_directed("basic");
        q_bin.delete(); q_mag.delete();
        load(3, 40, 1); load(30, 40, 1);
        test_directed("tie");
        vectors++;
        if (got_bin !== 5'd3 || got_peak !== 16'd40) begin
            miscompares++;
            $display("[TB] FAIL tie_low: got bin=%0d peak=%0d, need 3 40", got_bin, got_peak);
        end
        q_bin.delete(); q_mag.delete();
        load(0, 255, 3);
        test_directed("saturate");
        vectors++;
        if (got_peak_s !== 9'd511 || got_bin_s !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL sat9: got bin=%0d peak=%0d, need 0 511", got_bin_s, got_peak_s);
        end
        q_bin.delete(); q_mag.delete();
        load(0, 0, 1);
        test_directed("zero");
        q_bin.delete(); q_mag.delete();
        load(17, 255, 260); load(2, 1, 1);
        test_directed("heavy");
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        int eb, ep, eb9, ep9;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_bin   = 5'd4;
        in_mag   = 8'd200;
        repeat (2) @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, busy, out_valid, out_bin, out_peak} !== 24'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_reset: got rdy=%b busy=%b ov=%b bin=%0d peak=%0d, need all 0",
                     in_ready, busy, out_valid, out_bin, out_peak);
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || s_out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL abort_no_result: got out_valid=1 after abort, need 0");
        end
        q_bin.delete(); q_mag.delete();
        load(9, 1, 1);
        test_directed("after_abort");
        model_peak(1'b0, eb, ep);
        model_peak(1'b1, eb9, ep9);
        vectors++;
        if (got_bin !== 5'd9 || got_peak !== 16'd1 || got_peak_s !== 9'd1) begin
            miscompares++;
            $display("[TB] FAIL abort_stale: got bin=%0d peak=%0d/%0d, need 9 1/1",
                     got_bin, got_peak, got_peak_s);
        end
    endtask

    task automatic test_random(input bit noisy, input int windows);
        int n, lo, hi, eb, ep, eb9, ep9;
        for (int w = 0; w < windows; w++) begin
            q_bin.delete(); q_mag.delete();
            n  = $urandom_range(1, 40);
            lo = $urandom_range(0, 28);
            hi = ($urandom % 2 == 0) ? lo + 3 : 31;
            for (int i = 0; i < n; i++) begin
                q_bin.push_back($urandom_range(lo, hi));
                q_mag.push_back(($urandom % 3 == 0) ? 16 * $urandom_range(0, 15) : $urandom_range(0, 255));
            end
            run_window(noisy);
            model_peak(1'b0, eb, ep);
            model_peak(1'b1, eb9, ep9);
            vectors++;
            if (timeout || lat != 33) begin
                miscompares++;
                $display("[TB] FAIL rand%0d latency: got %0d (timeout=%0d), need 33", w, lat, timeout);
            end
            vectors++;
            if (got_bin !== 5'(eb) || got_peak !== 16'(ep) || got_bin_s !== 5'(eb9) || got_peak_s !== 9'(ep9)) begin
                miscompares++;
                $display("[TB] FAIL rand%0d result: got %0d/%0d %0d/%0d, need %0d/%0d %0d/%0d",
                         w, got_bin, got_peak, got_bin_s, got_peak_s, eb, ep, eb9, ep9);
            end
            vectors++;
            if (ov_after !== 1'b0 || busy_after !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rand%0d done_pulse: got ov=%b busy=%b, need 0 0", w, ov_after, busy_after);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_abort();
        test_random(1'b1, 4);
        test_random(1'b0, 10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
